// File: rtl/min_max_pkg.sv
// Shared types for the min/max LED bar display: display mode and the captured config word.
package min_max_pkg;

  // Widest supported VALSIZE; narrower instances zero-extend into these fields.
  localparam int unsigned MM_VAL_W = 8;

  typedef enum logic [1:0] {
    COM_NORMAL = 2'b00,
    COM_LINEAR = 2'b01,
    COM_OFF    = 2'b10,
    COM_ON     = 2'b11
  } com_t;

  typedef struct packed {
    com_t                com;
    logic [MM_VAL_W-1:0] min;
    logic [MM_VAL_W-1:0] max;
    logic [MM_VAL_W-1:0] val;
  } min_max_cfg_t;

endpackage

// File: rtl/min_max_blink_gen.sv
// Blink divider: counts 0..BLINK_DIV-1 and toggles osc on every wrap.
module min_max_blink_gen #(
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic osc_o
);

  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          osc_q, osc_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    osc_d = osc_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      osc_d = ~osc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      osc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      osc_q <= osc_d;
    end
  end

  assign osc_o = osc_q;

endmodule

// File: rtl/min_max_bar_disp.sv
// Clocked min/max LED bar: registered config, self-generated blink, registered LED bar.
// Optional decaying peak marker enabled by `define MIN_MAX_PEAK_HOLD_EN.
module min_max_bar_disp
  import min_max_pkg::*;
#(
  parameter int unsigned VALSIZE     = 4,
  parameter int unsigned BLINK_DIV   = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    val_i,
  output logic [2**VALSIZE-1:0] leds_o,
  output logic                  osc_o,
  output logic                  err_o
);

  localparam int unsigned N = 2**VALSIZE;
  typedef logic [MM_VAL_W-1:0] val_t;

  min_max_cfg_t cfg_q, cfg_d;
  logic         loaded_q;
  logic         osc;
  logic [N-1:0] le_val, le_max, ge_min, base_d, leds_d, leds_q;
  logic         rng_ok, in_rng, err_d, err_q;

  min_max_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .osc_o  (osc)
  );

  always_comb begin
    cfg_d = cfg_q;
    if (load_i)
      cfg_d = '{com: com_t'(com_i), min: val_t'(min_i), max: val_t'(max_i), val: val_t'(val_i)};
  end

  // The all-zero reset config would light bit 0 in normal mode; keep the bar dark until a real load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q    <= '{com: COM_NORMAL, min: '0, max: '0, val: '0};
      loaded_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      loaded_q <= loaded_q | load_i;
    end
  end

  always_comb begin
    ge_min = {N{1'b1}} << cfg_q.min;
    le_val = ~(({N{1'b1}} << cfg_q.val) << 1);
    le_max = ~(({N{1'b1}} << cfg_q.max) << 1);
    rng_ok = cfg_q.min <= cfg_q.max;
    in_rng = rng_ok && (cfg_q.min <= cfg_q.val) && (cfg_q.val <= cfg_q.max);
    base_d = '0;
    err_d  = 1'b0;
    if (loaded_q) begin
      case (cfg_q.com)
        COM_NORMAL: begin
          err_d = !rng_ok;
          if (in_rng) base_d = (le_val & ge_min) | (le_max & ~le_val & {N{osc}});
        end
        COM_LINEAR: base_d = le_val;
        COM_OFF:    base_d = '0;
        default:    base_d = '1;
      endcase
    end
  end

`ifdef MIN_MAX_PEAK_HOLD_EN
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RLD = HW'(HOLD_CYCLES);

  logic [VALSIZE-1:0] pk_q, pk_d;
  logic [HW-1:0]      hc_q, hc_d;
  val_t               pk_ext;
  logic               pk_show;

  always_comb begin
    pk_ext = val_t'(pk_q);
    pk_d   = pk_q;
    hc_d   = hc_q;
    if (load_i && !com_i[1] && (val_i > pk_q)) begin
      pk_d = val_i;
      hc_d = HOLD_RLD;
    end else begin
      if (hc_q != '0) begin
        hc_d = hc_q - HW'(1);
      end else if (pk_ext > cfg_q.val) begin
        pk_d = pk_q - VALSIZE'(1);
        hc_d = HOLD_RLD;
      end
      if (pk_ext < cfg_q.val) pk_d = cfg_q.val[VALSIZE-1:0];
    end
    pk_show = loaded_q && ((cfg_q.com == COM_LINEAR) ||
              ((cfg_q.com == COM_NORMAL) && rng_ok && (cfg_q.min <= pk_ext) && (pk_ext <= cfg_q.max)));
    leds_d  = base_d | (pk_show ? (N'(1) << pk_q) : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pk_q <= '0;
      hc_q <= '0;
    end else begin
      pk_q <= pk_d;
      hc_q <= hc_d;
    end
  end
`else
  assign leds_d = base_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      leds_q <= '0;
      err_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      err_q  <= err_d;
    end
  end

  assign leds_o = leds_q;
  assign err_o  = err_q;
  assign osc_o  = osc;

endmodule

// File: tb/tb_min_max_bar_disp.sv
// Scoreboard bench for min_max_bar_disp (VALSIZE=4, BLINK_DIV=4, HOLD_CYCLES=8).
module tb_min_max_bar_disp;

  localparam int BD   = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_ni, load_i;
  logic [1:0]  com_i;
  logic [3:0]  min_i, max_i, val_i;
  logic [15:0] leds_o;
  logic        osc_o, err_o;

  min_max_bar_disp #(.VALSIZE(4), .BLINK_DIV(BD), .HOLD_CYCLES(HOLD)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .load_i (load_i),
    .com_i  (com_i),
    .min_i  (min_i),
    .max_i  (max_i),
    .val_i  (val_i),
    .leds_o (leds_o),
    .osc_o  (osc_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_com, m_min, m_max, m_val, m_cnt, m_P, m_H;
  bit m_ld, m_osc;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_com = 0; m_min = 0; m_max = 0; m_val = 0;
    m_cnt = 0; m_P = 0; m_H = 0; m_ld = 0; m_osc = 0;
  endtask

  function automatic logic [15:0] mdl_leds();
    logic [15:0] e;
    e = '0;
    if (m_ld) begin
      case (m_com)
        0: if (m_min <= m_max && m_val >= m_min && m_val <= m_max) begin
             for (int i = 0; i < 16; i++) begin
               if (i >= m_min && i <= m_val) e[i] = 1'b1;
               else if (i > m_val && i <= m_max) e[i] = m_osc;
             end
           end
        1: for (int i = 0; i < 16; i++) e[i] = (i <= m_val);
        3: e = '1;
        default: e = '0;
      endcase
`ifdef MIN_MAX_PEAK_HOLD_EN
      if (m_com == 1 || (m_com == 0 && m_min <= m_max && m_P >= m_min && m_P <= m_max))
        e[m_P] = 1'b1;
`endif
    end
    return e;
  endfunction

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic step(input bit ld, input int com, input int mn, input int mx, input int v);
    logic [15:0] e_leds;
    logic        e_err;
    logic [17:0] got;
    logic [17:0] exp;
    load_i = ld;
    com_i  = 2'(com);
    min_i  = 4'(mn);
    max_i  = 4'(mx);
    val_i  = 4'(v);
    e_leds = mdl_leds();
    e_err  = m_ld && m_com == 0 && m_min > m_max;
`ifdef MIN_MAX_PEAK_HOLD_EN
    if (ld && com <= 1 && v > m_P) begin
      m_P = v; m_H = HOLD;
    end else begin
      if (m_H > 0) m_H--;
      else if (m_P > m_val) begin m_P--; m_H = HOLD; end
      if (m_P < m_val) m_P = m_val;
    end
`endif
    if (ld) begin
      m_com = com; m_min = mn; m_max = mx; m_val = v; m_ld = 1;
    end
    if (m_cnt == BD - 1) begin m_cnt = 0; m_osc = ~m_osc; end
    else m_cnt++;
    exp_q.push_back({m_osc, e_err, e_leds});
    @(posedge clk);
    #1;
    load_i = 1'b0;
    got = {osc_o, err_o, leds_o};
    exp = exp_q.pop_front();
    chk("leds", {16'h0, got[15:0]}, {16'h0, exp[15:0]});
    chk("err",  {31'h0, got[16]},   {31'h0, exp[16]});
    chk("osc",  {31'h0, got[17]},   {31'h0, exp[17]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mdl_reset();
  endtask

  bit saw_lo, saw_hi;

  initial begin
    rst_ni = 1'b0; load_i = 1'b0; com_i = '0; min_i = '0; max_i = '0; val_i = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_leds", {16'h0, leds_o}, 32'h0);
    chk("rst_osc",  {31'h0, osc_o},  32'h0);
    chk("rst_err",  {31'h0, err_o},  32'h0);
    rst_ni = 1'b1;

    // blink: first rise on the 4th edge after release
    idle(3);
    chk("osc_pre_rise", {31'h0, osc_o}, 32'h0);
    idle(1);
    chk("osc_rise", {31'h0, osc_o}, 32'h1);
    chk("noload_dark", {16'h0, leds_o}, 32'h0);
    idle(4);
    chk("osc_fall", {31'h0, osc_o}, 32'h0);

    // normal mode blinking bar
    step(1, 0, 3, 12, 8);
    saw_lo = 0; saw_hi = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      saw_lo |= (leds_o == 16'h01F8);
      saw_hi |= (leds_o == 16'h1FF8);
    end
    chk("blink_both", {30'h0, saw_hi, saw_lo}, 32'h3);

    // boundaries
    step(1, 0, 0, 15, 15); idle(1);
    chk("full_range", {16'h0, leds_o}, 32'hFFFF);
    step(1, 0, 0, 14, 15); idle(1);
    chk("val_above_max", {16'h0, leds_o}, 32'h0);
    step(1, 1, 0, 0, 5); idle(1);
`ifdef MIN_MAX_PEAK_HOLD_EN
    chk("linear5", {16'h0, leds_o}, 32'h803F);
`else
    chk("linear5", {16'h0, leds_o}, 32'h003F);
`endif

    // min > max error, then all-on
    step(1, 0, 10, 5, 7); idle(1);
    chk("err_set", {31'h0, err_o}, 32'h1);
    chk("err_dark", {16'h0, leds_o}, 32'h0);
    step(1, 3, 10, 5, 7); idle(1);
    chk("err_clr", {31'h0, err_o}, 32'h0);
    chk("all_on", {16'h0, leds_o}, 32'hFFFF);
    step(1, 2, 0, 0, 0); idle(1);
    chk("all_off", {16'h0, leds_o}, 32'h0);

    // peak hold / linear back-to-back loads
    do_reset();
    step(1, 1, 0, 0, 12);
    step(1, 1, 0, 0, 4);
    chk("lin12", {16'h0, leds_o}, 32'h1FFF);
    idle(1);
`ifdef MIN_MAX_PEAK_HOLD_EN
    chk("peak12_first", {16'h0, leds_o}, 32'h101F);
    idle(7);
    chk("peak12_last", {16'h0, leds_o}, 32'h101F);
    idle(1);
    chk("peak11", {16'h0, leds_o}, 32'h081F);
    idle(80);
`else
    chk("lin4", {16'h0, leds_o}, 32'h001F);
    idle(8);
`endif
    chk("peak_settled", {16'h0, leds_o}, 32'h001F);

    // async reset between edges
    step(1, 0, 3, 12, 8);
    idle(5);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_leds", {16'h0, leds_o}, 32'h0);
    chk("async_osc",  {31'h0, osc_o},  32'h0);
    chk("async_err",  {31'h0, err_o},  32'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mdl_reset();
    idle(6);
    chk("post_rst_dark", {16'h0, leds_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
